imem_boot_loader: RTL and testbench

- Upstream of the single-cycle core's instruction memory.
- Receives a framed program image as a byte stream (valid/ready, typically from the UART receiver) and assembles little-endian 32-bit words.
- Writes those words into IMEM through IMEM's write port, checks an XOR checksum, then asserts core_run to release the core from its hold.
- Core stays held while loading and after any error.

---
 rtl/imem_boot_loader.sv | 165 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Framed byte-stream boot loader: assembles little-endian words into IMEM, checks an XOR
// checksum and only then releases the core.
module imem_boot_loader #(
  parameter int          ADDR_W    = 10,
  parameter int          TIMEOUT   = 100000,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  input  logic              load_req_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              core_run_o,
  output logic              busy_o,
  output logic              error_o,
  output logic [1:0]        err_code_o,
  output logic [ADDR_W:0]   words_loaded_o
);

  localparam int         TW        = $clog2(TIMEOUT + 1);
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_SYNC, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          len_lo_q, len_lo_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     wl_q, wl_d;
  logic [1:0]          bidx_q, bidx_d;
  logic [23:0]         buf_q, buf_d;
  logic [7:0]          csum_q, csum_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [1:0]          err_code_q, err_code_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                accept;
  logic                active;
  logic [16:0]         n_len;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_SYNC;
      len_lo_q   <= '0;
      len_q      <= '0;
      wl_q       <= '0;
      bidx_q     <= '0;
      buf_q      <= '0;
      csum_q     <= '0;
      tmr_q      <= '0;
      err_code_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      wl_q       <= wl_d;
      bidx_q     <= bidx_d;
      buf_q      <= buf_d;
      csum_q     <= csum_d;
      tmr_q      <= tmr_d;
      err_code_q <= err_code_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign in_ready_o = (state_q != S_DONE) && (state_q != S_ERROR);
  assign active     = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                      (state_q == S_DATA) || (state_q == S_CSUM);
  assign accept     = in_valid_i && in_ready_o;
  assign n_len      = {1'b0, in_data_i, len_lo_q};

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    wl_d       = wl_q;
    bidx_d     = bidx_q;
    buf_d      = buf_q;
    csum_d     = csum_q;
    err_code_d = err_code_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    // Idle timer reloads on every accepted byte and counts down to terminal count zero.
    if (accept)            tmr_d = TW'(TIMEOUT - 1);
    else if (tmr_q != '0)  tmr_d = tmr_q - 1'b1;
    else                   tmr_d = tmr_q;

    case (state_q)
      S_SYNC: if (accept && in_data_i == SYNC_BYTE) state_d = S_LEN0;
      S_LEN0: if (accept) begin
        len_lo_d = in_data_i;
        state_d  = S_LEN1;
      end
      S_LEN1: if (accept) begin
        if (n_len == '0 || n_len > MAX_WORDS) begin
          state_d    = S_ERROR;
          err_code_d = 2'd1;
        end else begin
          state_d = S_DATA;
          len_d   = n_len[ADDR_W:0];
          wl_d    = '0;
          bidx_d  = '0;
          csum_d  = '0;
        end
      end
      S_DATA: if (accept) begin
        csum_d = csum_q ^ in_data_i;
        bidx_d = bidx_q + 1'b1;
        case (bidx_q)
          2'd0: buf_d[7:0]   = in_data_i;
          2'd1: buf_d[15:8]  = in_data_i;
          2'd2: buf_d[23:16] = in_data_i;
          default: begin
            we_d    = 1'b1;
            addr_d  = wl_q[ADDR_W-1:0];
            wdata_d = {in_data_i, buf_q};
            wl_d    = wl_q + 1'b1;
            if (wl_q + 1'b1 == len_q) state_d = S_CSUM;
          end
        endcase
      end
      S_CSUM: if (accept) begin
        if (in_data_i == csum_q) state_d = S_DONE;
        else begin
          state_d    = S_ERROR;
          err_code_d = 2'd2;
        end
      end
      S_DONE, S_ERROR: if (load_req_i) begin
        state_d    = S_SYNC;
        err_code_d = 2'd0;
        wl_d       = '0;
      end
      default: state_d = S_SYNC;
    endcase

    if (active && !accept && tmr_q == '0) begin
      state_d    = S_ERROR;
      err_code_d = 2'd3;
    end
  end

  assign imem_we_o      = we_q;
  assign imem_addr_o    = addr_q;
  assign imem_wdata_o   = wdata_q;
  assign core_run_o     = (state_q == S_DONE);
  assign error_o        = (state_q == S_ERROR);
  assign busy_o         = active;
  assign err_code_o     = err_code_q;
  assign words_loaded_o = wl_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader: frames are built from the framing rules and every
// IMEM write and end-of-frame status is compared against the bench's own expectations.
module tb_imem_boot_loader;

  localparam int         ADDR_W  = 6;
  localparam int         TIMEOUT = 50;
  localparam logic [7:0] SYNC    = 8'hA5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_ready;
  logic              load_req = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_run, busy, error;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   words_loaded;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] fw[$];
  int          exp_a[$];
  logic [31:0] exp_d[$];

  imem_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .SYNC_BYTE(SYNC)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .load_req_i(load_req), .imem_we_o(imem_we),
    .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata), .core_run_o(core_run),
    .busy_o(busy), .error_o(error), .err_code_o(err_code),
    .words_loaded_o(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Each observed write must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      if (exp_a.size() == 0) chk("we_extra", 32'd1, 32'd0);
      else begin
        chk("we_addr", 32'(imem_addr), 32'(exp_a.pop_front()));
        chk("we_data", imem_wdata, exp_d.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 100) begin step(1); n++; end
    if (n >= 100) chk("ready_timeout", 32'd0, 32'd1);
    step(1);
    if (gap > 0) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      step(gap);
    end
  endtask

  function automatic int rgap(input int gmax);
    return (gmax == 0) ? 0 : int'($urandom_range(gmax, 0));
  endfunction

  task automatic fill_random(input int n);
    fw.delete();
    for (int i = 0; i < n; i++) fw.push_back($urandom);
  endtask

  // Sends SYNC, length, fw[0..n-1] little-endian and the XOR checksum (optionally corrupted).
  task automatic send_frame(input int n, input int gmax, input bit bad);
    logic [7:0]  cs = 8'h00;
    logic [15:0] nn = 16'(n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      exp_a.push_back(i);
      exp_d.push_back(fw[i]);
    end
    send_byte(SYNC, rgap(gmax));
    send_byte(nn[7:0], rgap(gmax));
    send_byte(nn[15:8], rgap(gmax));
    for (int i = 0; i < n; i++) begin
      w = fw[i];
      for (int b = 0; b < 4; b++) begin
        cs ^= w[8*b +: 8];
        send_byte(w[8*b +: 8], rgap(gmax));
      end
    end
    send_byte(bad ? (cs ^ 8'h01) : cs, 0);
    in_valid = 1'b0;
    step(2);
  endtask

  task automatic check_end(input string tag, input bit ok, input int code, input int wl);
    chk({tag, "_core_run"}, 32'(core_run), 32'(ok));
    chk({tag, "_error"}, 32'(error), 32'(!ok));
    chk({tag, "_err_code"}, 32'(err_code), 32'(code));
    chk({tag, "_words"}, 32'(words_loaded), 32'(wl));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_core_run"}, 32'(core_run), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_err_code"}, 32'(err_code), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_we"}, 32'(imem_we), 32'd0);
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    step(1);
    load_req = 1'b0;
    check_idle("reload");
  endtask

  initial begin
    int n;
    bit bad;
    step(3);
    rst = 1'b0;
    step(1);
    check_idle("reset");
    chk("reset_wdata", imem_wdata, 32'h0);
    chk("reset_addr", 32'(imem_addr), 32'h0);

    // Two-word program, good checksum.
    fw.delete();
    fw.push_back(32'h0000_0013);
    fw.push_back(32'h0010_0093);
    send_frame(2, 0, 1'b0);
    check_end("prog", 1'b1, 0, 2);
    pulse_load_req();

    // Same frame with corrupted checksum, then recovery.
    send_frame(2, 2, 1'b1);
    check_end("badcs", 1'b0, 2, 2);
    pulse_load_req();
    send_frame(2, 2, 1'b0);
    check_end("recover", 1'b1, 0, 2);
    pulse_load_req();

    // Garbage before SYNC, zero length, then oversize length.
    send_byte(8'h00, 1);
    send_byte(8'hFF, 0);
    send_byte(8'h12, 0);
    in_valid = 1'b0;
    chk("garbage_busy", 32'(busy), 32'd0);
    send_byte(SYNC, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    in_valid = 1'b0;
    step(2);
    check_end("len0", 1'b0, 1, 0);
    pulse_load_req();
    n = (1 << ADDR_W) + 1;
    send_byte(SYNC, 0);
    send_byte(8'(n), 0);
    send_byte(8'(n >> 8), 0);
    in_valid = 1'b0;
    step(2);
    check_end("lenbig", 1'b0, 1, 0);
    pulse_load_req();

    // Stream stalls after 5 data bytes: abort exactly TIMEOUT cycles after the last byte.
    fill_random(2);
    exp_a.push_back(0);
    exp_d.push_back(fw[0]);
    send_byte(SYNC, 0);
    send_byte(8'd2, 0);
    send_byte(8'd0, 0);
    for (int b = 0; b < 4; b++) send_byte(8'(fw[0] >> (8*b)), 0);
    send_byte(8'(fw[1]), 0);
    in_valid = 1'b0;
    step(TIMEOUT - 1);
    chk("tmo_before", 32'(error), 32'd0);
    chk("tmo_busy_before", 32'(busy), 32'd1);
    step(1);
    check_end("tmo", 1'b0, 3, 1);
    pulse_load_req();

    // Reset mid-DATA after word 0 has been written, then a clean frame from address 0.
    fill_random(2);
    exp_a.push_back(0);
    exp_d.push_back(fw[0]);
    send_byte(SYNC, 0);
    send_byte(8'd2, 0);
    send_byte(8'd0, 0);
    for (int b = 0; b < 4; b++) send_byte(8'(fw[0] >> (8*b)), 0);
    in_valid = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_idle("midrst");
    chk("midrst_wdata", imem_wdata, 32'h0);
    fill_random(3);
    send_frame(3, 1, 1'b0);
    check_end("after_rst", 1'b1, 0, 3);
    pulse_load_req();

    // Back-to-back bytes with in_valid held high throughout.
    fill_random(4);
    send_frame(4, 0, 1'b0);
    check_end("b2b", 1'b1, 0, 4);
    pulse_load_req();

    // Full-capacity frame.
    fill_random(1 << ADDR_W);
    send_frame(1 << ADDR_W, 0, 1'b0);
    check_end("full", 1'b1, 0, 1 << ADDR_W);
    pulse_load_req();

    // Random frames.
    for (int k = 0; k < 6; k++) begin
      n   = int'($urandom_range(12, 1));
      bad = 1'($urandom_range(1, 0));
      fill_random(n);
      send_frame(n, 3, bad);
      check_end("rand", !bad, bad ? 2 : 0, n);
      pulse_load_req();
    end

    chk("writes_pending", 32'(exp_a.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
